tensor_stream_packer: RTL and testbench
=======================================

# tensor_stream_packer

Write-side feeder for `relu_binary_clk_array`. It accepts tensor elements one per beat on a valid/ready stream and assembles them into the flat packed `out_tensor` word the array consumes. It presents each completed tensor with a valid/ready handshake. Lane ordering matches the array: element 0 in the LSBs.

## Interface
- `DATA_WIDTH`, 8, bits per element (two's complement)
- `BATCH_SIZE`, 1, tensor batch dimension
- `CHANNELS`, 1, tensor channel dimension
- `HEIGHT`, 2, tensor height
- `WIDTH`, 2, tensor width
- Derived (localparam):
  - `TENSOR_SIZE` = BATCH_SIZE*CHANNELS*HEIGHT*WIDTH
  - `TOTAL_WIDTH` = TENSOR_SIZE*DATA_WIDTH
  - `CNT_W` = max(1, $clog2(TENSOR_SIZE))

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_WIDTH  element payload
- `in_valid`  in  1  element present
- `in_last`  in  1  marks final element of a tensor
- `in_ready`  out  1  packer accepts element this cycle
- `out_tensor`  out  TOTAL_WIDTH  packed tensor; element i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `out_valid`  out  1  `out_tensor` holds a complete tensor
- `out_ready`  in  1  downstream takes tensor
- `err_len`  out  1  sticky length error

## Operation
- **Acceptance**
  - An element is accepted on `in_valid && in_ready`.
  - The element is written to the fill-buffer lane at index `cnt`, then `cnt` increments.
- **States**
  - `FILL`
    - `in_ready` = 1.
    - Tensor completes on the accept where `cnt == TENSOR_SIZE-1` or `in_last` = 1.
    - On completion: fill buffer goes to `out_tensor`, `out_valid` <= 1, `cnt` <= 0, state -> `HOLD`.
  - `HOLD`
    - `in_ready` = 0.
    - On `out_valid && out_ready`: `out_valid` <= 0, state -> `FILL`.
- **Fill buffer**
  - Cleared to zero when each new tensor starts.
  - Lanes not written before completion read as 0.
- **Length checks** (`err_len` set to 1; cleared only by reset)
  - `in_last` on index < TENSOR_SIZE-1: tensor completes early with the remaining lanes zero.
  - Index TENSOR_SIZE-1 accepted with `in_last` = 0: tensor completes anyway.
- **Signedness:** no arithmetic on data; bits pass through unaltered.
- **Reset:** all state is discarded immediately, including any partial tensor and any held tensor. Nothing from before reset is ever emitted.

## Timing
- **Reset values**
  - `out_valid` = 0, `out_tensor` = 0, `err_len` = 0
  - `cnt` = 0, state `FILL`
  - `in_ready` = 1 once `reset` deasserts. `in_ready` is combinational from state only and never depends on `in_valid`.
- **Latency:** `out_valid` rises the cycle after the final element is accepted.
- **Output hold:** `out_tensor` and `out_valid` are registered. They stay stable while `out_valid && !out_ready`.
- **Throughput (single buffer):** TENSOR_SIZE+1 cycles per tensor with `out_ready` tied high. The single bubble is the `HOLD` cycle.
- **`out_ready` outside `HOLD`:** ignored when `out_valid` = 0.
- **TENSOR_SIZE = 1:** every accepted element completes a tensor.

## Configuration
- `PACKER_DOUBLE_BUFFER_EN` defined:
  - A separate fill buffer keeps accepting elements while `out_valid` = 1.
  - `in_ready` = 0 only when the fill buffer is complete and `out_valid && !out_ready`.
  - A completed fill buffer moves to `out_tensor` on the handshake cycle or, if the output is empty, on the completion edge.
  - Sustained rate is 1 element/cycle with no bubble.
  - A fill completing in the same cycle as an output handshake is transferred directly; `out_valid` stays 1.
- Undefined: single-buffer `FILL`/`HOLD` behaviour as above.

## Test plan
- **Basic packing:** reset low 2 cycles, then stream FF, 7F, 01, 80 with `in_last` on 80 and `out_ready` = 1.
  - `out_tensor` = 32'h80017FFF and `out_valid` pulses 1 cycle, the cycle after 80 is accepted.
  - `err_len` = 0.
- **Backpressure:** same stream with `out_ready` = 0 for 5 cycles.
  - `out_tensor` is held stable.
  - Single buffer: `in_ready` = 0 throughout.
  - Handshake on the 6th cycle returns `in_ready` = 1.
- **Early last:** stream AA, BB with `in_last` on BB.
  - `out_tensor` = 32'h0000BBAA, `err_len` = 1 and stays 1 through the next clean tensor.
- **Missing last:** 4 elements 11, 22, 33, 44 with no `in_last`.
  - `out_tensor` = 32'h44332211, `err_len` = 1.
- **Reset mid-fill:** accept 2 elements, pulse `reset` low asynchronously between clock edges.
  - `out_valid`/`out_tensor`/`cnt` are 0 immediately.
  - Next 4-element tensor packs correctly.
- **Double buffer (`PACKER_DOUBLE_BUFFER_EN`):** two back-to-back tensors with `out_ready` = 1.
  - 8 elements accepted in 8 consecutive cycles.
  - Two `out_valid` tensors in order with no gap on `in_ready`.

Source files
------------

// File: rtl/tensor_stream_packer.sv
// tensor_stream_packer
//   Collects tensor elements, one per beat, into the flat packed word consumed
//   by relu_binary_clk_array (element 0 in the LSBs) and offers each finished
//   tensor downstream.
//
//   Optional feature macro: PACKER_DOUBLE_BUFFER_EN
//     undefined : single buffer, FILL/HOLD, one bubble cycle per tensor
//     defined   : a separate fill buffer keeps accepting while a tensor is held
//
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid && ready are both 1. A producer holding valid keeps its payload
//   stable until that edge. in_ready depends only on internal state (and on
//   out_ready in the double-buffer build), never on in_valid.
//
//   dbg_state / dbg_cnt expose the control state for observation only.
module tensor_stream_packer #(
    parameter int DATA_WIDTH    = 8,
    parameter int BATCH_SIZE    = 1,
    parameter int CHANNELS      = 1,
    parameter int HEIGHT        = 2,
    parameter int WIDTH         = 2,
    localparam int TENSOR_SIZE  = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH,
    localparam int TOTAL_WIDTH  = TENSOR_SIZE * DATA_WIDTH,
    localparam int CNT_W        = (TENSOR_SIZE > 1) ? $clog2(TENSOR_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [TOTAL_WIDTH-1:0] out_tensor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_len,
    output logic [0:0]             dbg_state,
    output logic [CNT_W-1:0]       dbg_cnt
);

    logic [0:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [TOTAL_WIDTH-1:0] fill_buf;
    logic [TOTAL_WIDTH-1:0] base_buf;
    logic [TOTAL_WIDTH-1:0] wr_buf;
    logic                   accept;
    logic                   at_end;
    logic                   complete;
    logic                   len_bad;
    logic                   out_fire;

    assign accept    = in_valid && in_ready;
    assign at_end    = (cnt == CNT_W'(TENSOR_SIZE - 1));
    assign complete  = accept && (in_last || at_end);
    // in_last on a short tensor, or a full tensor without in_last
    assign len_bad   = accept && (in_last != at_end);
    assign out_fire  = out_valid && out_ready;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    // Fill buffer with the incoming element dropped into lane cnt
    always_comb begin
        wr_buf = base_buf;
        wr_buf[int'(cnt) * DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Sticky length error, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_len <= 1'b0;
        end else if (len_bad) begin
            err_len <= 1'b1;
        end
    end

`ifdef PACKER_DOUBLE_BUFFER_EN

    // FILL: fill_buf is a partial tensor. FULL: fill_buf holds a finished
    // tensor waiting for the output register to free up.
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    assign in_ready = !((state == FULL) && out_valid && !out_ready);
    // A pending tensor leaves this cycle whenever we accept, so a new tensor
    // starts from an all-zero buffer.
    assign base_buf = (state == FULL) ? '0 : fill_buf;

    // Fill/pending buffer and output register management
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            cnt        <= '0;
            fill_buf   <= '0;
            out_tensor <= '0;
            out_valid  <= 1'b0;
        end else if (state == FULL) begin
            if (out_fire) begin
                out_tensor <= fill_buf;
                if (complete) begin
                    fill_buf <= wr_buf;
                    cnt      <= '0;
                end else if (accept) begin
                    fill_buf <= wr_buf;
                    cnt      <= cnt + 1'b1;
                    state    <= FILL;
                end else begin
                    fill_buf <= '0;
                    state    <= FILL;
                end
            end
        end else begin
            if (complete) begin
                cnt <= '0;
                if (!out_valid || out_ready) begin
                    // Output empty or emptying now: move straight across
                    out_tensor <= wr_buf;
                    out_valid  <= 1'b1;
                    fill_buf   <= '0;
                end else begin
                    fill_buf <= wr_buf;
                    state    <= FULL;
                end
            end else begin
                if (accept) begin
                    fill_buf <= wr_buf;
                    cnt      <= cnt + 1'b1;
                end
                if (out_fire) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`else

    // FILL: accepting elements. HOLD: finished tensor offered downstream.
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    assign in_ready = (state == FILL);
    assign base_buf = fill_buf;

    // FILL/HOLD sequencing with buffer and output register updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            cnt        <= '0;
            fill_buf   <= '0;
            out_tensor <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (complete) begin
                        out_tensor <= wr_buf;
                        out_valid  <= 1'b1;
                        fill_buf   <= '0;
                        cnt        <= '0;
                        state      <= HOLD;
                    end else if (accept) begin
                        fill_buf <= wr_buf;
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= FILL;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_tensor_stream_packer.sv
// tb_tensor_stream_packer
//   Directed table of tensors, hand-written multi-cycle sequences and random
//   traffic, all checked against a queue-based reference model.
module tb_tensor_stream_packer;

    localparam int DW = 8;
    localparam int TS = 4;
    localparam int TW = TS * DW;
    localparam int CW = 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [TW-1:0] out_tensor;
    logic          out_valid;
    logic          out_ready;
    logic          err_len;
    logic [0:0]    dbg_state;
    logic [CW-1:0] dbg_cnt;

    always #5 clk = ~clk;

    tensor_stream_packer #(
        .DATA_WIDTH(DW), .BATCH_SIZE(1), .CHANNELS(1), .HEIGHT(2), .WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_tensor(out_tensor), .out_valid(out_valid), .out_ready(out_ready),
        .err_len(err_len), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;
    logic [TW-1:0] exp_q[$];   // finished tensors not yet taken downstream
    logic [DW-1:0] cur_q[$];   // elements of the tensor being collected
    bit            m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input bit ordy);
`ifdef PACKER_DOUBLE_BUFFER_EN
        return (exp_q.size() < 2) || ordy;
`else
        return exp_q.size() == 0;
`endif
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit l);
        logic [TW-1:0] t;
        cur_q.push_back(d);
        if (l || cur_q.size() == TS) begin
            if (l != (cur_q.size() == TS)) m_err = 1'b1;
            t = '0;
            for (int i = 0; i < cur_q.size(); i++) t = t | (TW'(cur_q[i]) << (i * DW));
            exp_q.push_back(t);
            cur_q.delete();
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        exp_q.delete();
        m_err = 1'b0;
    endtask

    // ---------------- driver ----------------
    // One clock: check outputs at the falling edge, then advance model and DUT.
    task automatic step(output bit acc);
        bit            fire;
        logic [DW-1:0] d;
        bit            l;
        @(negedge clk);
        check("in_ready", in_ready, model_in_ready(out_ready));
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("out_tensor", out_tensor, exp_q[0]);
        check("err_len", err_len, m_err);
        acc  = in_valid && model_in_ready(out_ready);
        fire = (exp_q.size() != 0) && out_ready;
        d    = in_data;
        l    = in_last;
        @(posedge clk);
        if (fire) void'(exp_q.pop_front());
        if (acc) model_accept(d, l);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit l);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 20; k++) begin
            step(acc);
            if (acc) break;
            if (k == 19) check("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [DW-1:0] elem [TS];
        int            n;
        bit            last_on_end;
        logic [TW-1:0] exp_tensor;
        bit            exp_err;
    } vec_t;

    vec_t vecs[4];
    bit   acc;
    int   n_acc;
    logic [TW-1:0] held;

    initial begin
        vecs[0] = '{elem: '{8'hFF, 8'h7F, 8'h01, 8'h80}, n: 4, last_on_end: 1'b1, exp_tensor: 32'h80017FFF, exp_err: 1'b0};
        vecs[1] = '{elem: '{8'hAA, 8'hBB, 8'h00, 8'h00}, n: 2, last_on_end: 1'b1, exp_tensor: 32'h0000BBAA, exp_err: 1'b1};
        vecs[2] = '{elem: '{8'h11, 8'h22, 8'h33, 8'h44}, n: 4, last_on_end: 1'b0, exp_tensor: 32'h44332211, exp_err: 1'b1};
        vecs[3] = '{elem: '{8'h01, 8'h02, 8'h03, 8'h04}, n: 4, last_on_end: 1'b1, exp_tensor: 32'h04030201, exp_err: 1'b1};

        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tensor", out_tensor, 0);
        check("rst_err_len", err_len, 0);
        check("rst_cnt", dbg_cnt, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: each tensor streamed with out_ready high
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < vecs[v].n; j++)
                send(vecs[v].elem[j], vecs[v].last_on_end && (j == vecs[v].n - 1));
            #3;
            check("tbl_valid", out_valid, 1);
            check("tbl_tensor", out_tensor, vecs[v].exp_tensor);
            check("tbl_err", err_len, vecs[v].exp_err);
            step(acc);
            #3;
            check("tbl_pulse", out_valid, 0);
            step(acc);
        end

        // Backpressure: tensor held for 5 cycles, released on the 6th
        out_ready = 1'b0;
        send(8'hFF, 1'b0);
        send(8'h7F, 1'b0);
        send(8'h01, 1'b0);
        send(8'h80, 1'b1);
        held = 32'h80017FFF;
        for (int c = 0; c < 5; c++) begin
            #3;
            check("bp_hold_tensor", out_tensor, held);
            check("bp_hold_valid", out_valid, 1);
`ifndef PACKER_DOUBLE_BUFFER_EN
            check("bp_in_ready", in_ready, 0);
`endif
            step(acc);
        end
        out_ready = 1'b1;
        step(acc);
        #3;
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        step(acc);

        // Reset mid-fill, asserted between clock edges
        send(8'h5A, 1'b0);
        send(8'hA5, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_tensor", out_tensor, 0);
        check("mid_rst_cnt", dbg_cnt, 0);
        check("mid_rst_err", err_len, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hEF, 1'b1);
        #3;
        check("post_rst_tensor", out_tensor, 32'hEFBEADDE);
        check("post_rst_err", err_len, 0);
        step(acc);
        step(acc);

`ifdef PACKER_DOUBLE_BUFFER_EN
        // Two back-to-back tensors, one element per cycle
        n_acc = 0;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_data  = DW'(j + 1);
            in_last  = (j % 4) == 3;
            step(acc);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("db_accepts", n_acc, 8);
        repeat (3) step(acc);
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = DW'($urandom);
            in_last   = $urandom_range(0, 7) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            step(acc);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(acc);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
